// File: rtl/memory_ram.sv
// Single-port RAM of D x W words behind valid/ready write-address, write-data,
// read-address and read-data channels; writes commit once both halves are held.
module memory_ram #(
    parameter int W = 16,
    parameter int D = 256,
    localparam int A = (D > 1) ? $clog2(D) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] aw_data,
    input  logic         aw_valid,
    output logic         aw_ready,
    input  logic [W-1:0] w_data,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [A-1:0] ar_data,
    input  logic         ar_valid,
    output logic         ar_ready,
    output logic [W-1:0] r_data,
    output logic         r_valid,
    input  logic         r_ready
);

    localparam logic [A:0] DEPTH = (A + 1)'(D);

    logic [W-1:0] mem [D];

    logic         aw_full;
    logic         w_full;
    logic [A-1:0] aw_addr_q;
    logic [W-1:0] w_data_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic r_hs;
    logic commit;
    logic wr_in_range;
    logic rd_in_range;

    // Readies are held low for the whole reset so nothing is accepted mid-reset.
    assign aw_ready = !rst && !aw_full;
    assign w_ready  = !rst && !w_full;
    assign ar_ready = !rst && (!r_valid || r_ready);

    assign aw_hs  = aw_valid && aw_ready;
    assign w_hs   = w_valid && w_ready;
    assign ar_hs  = ar_valid && ar_ready;
    assign r_hs   = r_valid && r_ready;
    assign commit = aw_full && w_full;

    assign wr_in_range = {1'b0, aw_addr_q} < DEPTH;
    assign rd_in_range = {1'b0, ar_data} < DEPTH;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= aw_data;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= w_data;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM and keeps its
    // contents across rst; only the control registers around it are reset.
    always_ff @(posedge clk) begin
        if (commit && wr_in_range) begin
            mem[aw_addr_q] <= w_data_q;
        end
    end

    // A read on the same edge as a commit sees the pre-commit contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            r_data  <= rd_in_range ? mem[ar_data] : '0;
        end else if (r_hs) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_ram.sv
// Directed self-checking bench for memory_ram: fill/readback, skewed writes,
// read backpressure, streaming reads, read-after-write and reset behaviour.
module tb_memory_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aw_data = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [15:0] w_data = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [7:0]  ar_data = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_ready = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] exp_mem [256];

    memory_ram #(.W(16), .D(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .aw_data  (aw_data),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .w_data   (w_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .ar_data  (ar_data),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .r_data   (r_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Stimulus helpers are entered and left on a falling edge.
    task automatic write_word(input logic [7:0] addr, input logic [15:0] data);
        bit a_done = 1'b0;
        bit d_done = 1'b0;
        bit a_rdy;
        bit d_rdy;
        aw_data = addr; w_data = data; aw_valid = 1'b1; w_valid = 1'b1;
        for (int i = 0; i < 20 && !(a_done && d_done); i++) begin
            #1;
            a_rdy = aw_ready; d_rdy = w_ready;
            @(posedge clk);
            if (a_rdy) a_done = 1'b1;
            if (d_rdy) d_done = 1'b1;
            @(negedge clk);
            if (a_done) aw_valid = 1'b0;
            if (d_done) w_valid = 1'b0;
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        compared++;
        if (!(a_done && d_done)) begin
            mismatched++;
            $display("FAIL write_handshake addr=%h: aw_done=%0b w_done=%0b, required both 1", addr, a_done, d_done);
        end
        @(posedge clk);
        @(negedge clk);
        exp_mem[addr] = data;
    endtask

    task automatic read_word(input logic [7:0] addr, output logic [15:0] data, output logic ok);
        bit done = 1'b0;
        bit rdy;
        ar_data = addr; ar_valid = 1'b1; r_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            rdy = ar_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            @(negedge clk);
            if (done) ar_valid = 1'b0;
        end
        ar_valid = 1'b0;
        #1;
        data = r_data;
        ok = done && r_valid;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        compared++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_readies: got %b, required 000", {aw_ready, w_ready, ar_ready});
        end
        compared++;
        if (r_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_r_valid: got %b, required 0", r_valid);
        end
        compared++;
        if (r_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_r_data: got %h, required 0000", r_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
            mismatched++;
            $display("FAIL post_reset_readies: got %b, required 111", {aw_ready, w_ready, ar_ready});
        end
        @(negedge clk);
    endtask

    task automatic test_fill_readback();
        logic [15:0] d;
        logic ok;
        for (int i = 0; i < 256; i++) begin
            write_word(8'(i), 16'(i * 40503) ^ 16'h5A5A);
        end
        for (int i = 0; i < 256; i++) begin
            read_word(8'(i), d, ok);
            compared++;
            if (!ok || d !== exp_mem[i]) begin
                mismatched++;
                $display("FAIL fill_read[%0d]: got %h valid=%0b, required %h", i, d, ok, exp_mem[i]);
            end
        end
    endtask

    task automatic test_skewed_write();
        logic [15:0] d;
        logic ok;
        aw_data = 8'h05; aw_valid = 1'b1;
        #1;
        compared++;
        if (aw_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL skew_aw_accept: aw_ready=%b, required 1", aw_ready);
        end
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            compared++;
            if (aw_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL skew_aw_held[%0d]: aw_ready=%b, required 0", k, aw_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        w_data = 16'hBEEF; w_valid = 1'b1;
        #1;
        compared++;
        if ({w_ready, aw_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL skew_w_accept: w_ready,aw_ready=%b, required 10", {w_ready, aw_ready});
        end
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        compared++;
        if (aw_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL skew_pre_commit: aw_ready=%b, required 0", aw_ready);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if ({aw_ready, w_ready} !== 2'b11) begin
            mismatched++;
            $display("FAIL skew_post_commit: aw_ready,w_ready=%b, required 11", {aw_ready, w_ready});
        end
        exp_mem[8'h05] = 16'hBEEF;
        @(negedge clk);
        read_word(8'h05, d, ok);
        compared++;
        if (!ok || d !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL skew_read: got %h valid=%0b, required beef", d, ok);
        end
    endtask

    task automatic test_read_backpressure();
        ar_data = 8'h05; ar_valid = 1'b1; r_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            compared++;
            if ({r_valid, ar_ready} !== 2'b10 || r_data !== 16'hBEEF) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: r_valid=%b ar_ready=%b r_data=%h, required 1 0 beef", k, r_valid, ar_ready, r_data);
            end
            @(posedge clk);
            @(negedge clk);
        end
        r_ready = 1'b1;
        #1;
        compared++;
        if (ar_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release_ready: ar_ready=%b, required 1", ar_ready);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (r_valid !== 1'b0 || r_data !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL bp_consumed: r_valid=%b r_data=%h, required 0 beef", r_valid, r_data);
        end
        @(negedge clk);
    endtask

    task automatic test_streaming_reads();
        r_ready = 1'b1;
        ar_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) ar_data = 8'(k);
            else ar_valid = 1'b0;
            #1;
            if (k < 3) begin
                compared++;
                if (ar_ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL stream_ar_ready[%0d]: got %b, required 1", k, ar_ready);
                end
            end
            if (k > 0) begin
                compared++;
                if (r_valid !== 1'b1 || r_data !== exp_mem[k-1]) begin
                    mismatched++;
                    $display("FAIL stream_beat[%0d]: r_valid=%b r_data=%h, required 1 %h", k - 1, r_valid, r_data, exp_mem[k-1]);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        compared++;
        if (r_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_drain: r_valid=%b, required 0", r_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_read_after_write();
        logic [15:0] old_val;
        logic [15:0] d;
        logic ok;
        old_val = exp_mem[8'h20];
        aw_data = 8'h20; w_data = 16'hC0DE; aw_valid = 1'b1; w_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        ar_data = 8'h20; ar_valid = 1'b1; r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        #1;
        compared++;
        if (r_valid !== 1'b1 || r_data !== old_val) begin
            mismatched++;
            $display("FAIL raw_same_edge: r_valid=%b r_data=%h, required 1 %h", r_valid, r_data, old_val);
        end
        exp_mem[8'h20] = 16'hC0DE;
        @(posedge clk);
        @(negedge clk);
        read_word(8'h20, d, ok);
        compared++;
        if (!ok || d !== 16'hC0DE) begin
            mismatched++;
            $display("FAIL raw_later: got %h valid=%0b, required c0de", d, ok);
        end
    endtask

    task automatic test_reset_retention();
        logic [15:0] d;
        logic ok;
        write_word(8'hFF, 16'h1234);
        ar_data = 8'h00; ar_valid = 1'b1; r_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        #1;
        compared++;
        if (r_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL ret_pending: r_valid=%b, required 1", r_valid);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({r_valid, aw_ready, w_ready, ar_ready} !== 4'b0000 || r_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL ret_in_reset: r_valid,readies=%b r_data=%h, required 0000 0000", {r_valid, aw_ready, w_ready, ar_ready}, r_data);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        r_ready = 1'b1;
        #1;
        compared++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
            mismatched++;
            $display("FAIL ret_after_reset: readies=%b, required 111", {aw_ready, w_ready, ar_ready});
        end
        @(negedge clk);
        read_word(8'hFF, d, ok);
        compared++;
        if (!ok || d !== 16'h1234) begin
            mismatched++;
            $display("FAIL ret_read: got %h valid=%0b, required 1234", d, ok);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] d;
        logic ok;
        aw_data = 8'h10; aw_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        rst = 1'b1;
        #1;
        compared++;
        if (aw_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL midw_in_reset: aw_ready=%b, required 0", aw_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (aw_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL midw_aw_discarded: aw_ready=%b, required 1", aw_ready);
        end
        w_data = 16'hAAAA; w_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        compared++;
        if (w_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL midw_w_held: w_ready=%b, required 0", w_ready);
        end
        @(negedge clk);
        read_word(8'h10, d, ok);
        compared++;
        if (!ok || d !== exp_mem[8'h10]) begin
            mismatched++;
            $display("FAIL midw_no_write: got %h valid=%0b, required %h", d, ok, exp_mem[8'h10]);
        end
        aw_data = 8'h10; aw_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_mem[8'h10] = 16'hAAAA;
        read_word(8'h10, d, ok);
        compared++;
        if (!ok || d !== 16'hAAAA) begin
            mismatched++;
            $display("FAIL midw_new_aw: got %h valid=%0b, required aaaa", d, ok);
        end
    endtask

    initial begin
        test_reset();
        test_fill_readback();
        test_skewed_write();
        test_read_backpressure();
        test_streaming_reads();
        test_read_after_write();
        test_reset_retention();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/memory_ram.md
# memory_ram

Single-clock, single-port-array RAM of D words × W bits behind four valid/ready streaming channels: write address (aw), write data (w), read address (ar) and read data (r). It serves as a generic addressable storage element for stream-connected datapaths. Writes complete when both an address and a data beat have been accepted. Reads return one data beat per accepted address, in order.

## Interface
- W, default 16: data word width in bits.
- D, default 256: depth in words; A = $clog2(D) is the address width.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- aw_data  input  A  write address.
- aw_valid  input  1  write address valid.
- aw_ready  output  1  write address accepted when high with aw_valid.
- w_data  input  W  write data.
- w_valid  input  1  write data valid.
- w_ready  output  1  write data accepted when high with w_valid.
- ar_data  input  A  read address.
- ar_valid  input  1  read address valid.
- ar_ready  output  1  read address accepted when high with ar_valid.
- r_data  output  W  read data.
- r_valid  output  1  read data valid.
- r_ready  input  1  read data consumed when high with r_valid.

The module has one clock; reset is asynchronous and active-high.

## Operation
- A beat transfers on a rising edge where valid && ready. Sources hold data stable while valid && !ready.
- Write path:
  - A one-entry address holding register (aw_full) and a one-entry data holding register (w_full) are loaded independently. aw_ready = !aw_full; w_ready = !w_full.
  - aw and w beats arrive in either order or together.
  - On the edge where aw_full && w_full, mem[addr] <= data and both registers clear.
  - Sustained throughput is one write per 2 cycles.
- Read path:
  - ar_ready = !r_valid || r_ready.
  - On an ar handshake: r_data <= mem[ar_data]; r_valid <= 1.
  - On an r handshake without a new ar handshake: r_valid <= 0 and r_data holds its value.
  - Back-to-back reads at one per cycle are supported while r_ready = 1.
  - r_data holds stable while r_valid && !r_ready.
- Read and write paths are independent. Either may stall without blocking the other.
- Addresses are always in range when D is a power of two. For non-power-of-two D, accesses to addresses ≥ D are ignored on write and return 0 on read.
- Array contents are not initialised and are not cleared by reset. Contents survive rst.

## Timing
- While rst is asserted: aw_full = w_full = 0, r_valid = 0, r_data = 0, and aw_ready = w_ready = ar_ready = 0 (all readies are gated by !rst).
- After rst deasserts, aw_ready = w_ready = ar_ready = 1 combinationally.
- Write commit occurs 1 cycle after the later of the aw and w handshakes.
- Read latency: r_valid rises 1 cycle after the ar handshake.
- Read-after-write: an ar handshake on the commit edge or later returns the newly written data only if accepted at least 1 edge after the commit. An ar handshake on the same edge as a commit to the same address returns the old data.
- Reset mid-transaction discards a half-collected write (aw or w held) and any pending r beat. No partial write occurs.

## Test plan
- Fill and readback: after reset, write mem[i] = random 16-bit for i = 0..255 (aw and w presented simultaneously) -> reading i = 0..255 returns each written value exactly.
- Skewed write: aw = 0x05 presented 3 cycles before w = 0xBEEF -> aw_ready low until the commit; a read of 0x05 returns 0xBEEF.
- Read backpressure: ar = 0x05 with r_ready held low 4 cycles -> r_valid = 1 and r_data = 0xBEEF stable, ar_ready = 0 throughout; the r beat transfers when r_ready rises.
- Streaming reads: ar = 0, 1, 2 on consecutive cycles with r_ready = 1 -> r beats on 3 consecutive cycles in order, 1-cycle latency.
- Reset retention: write 0x1234 to address 0xFF, pulse rst -> r_valid = 0 during reset, readies low; after reset, a read of 0xFF returns 0x1234.
- Reset mid-write: aw = 0x10 accepted, rst asserted before w arrives, then w = 0xAAAA alone after reset -> no write to 0x10 until a new aw arrives.
